// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read, holds the result until decode takes it.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_fault after TIMEOUT_CYCLES without mem_ack.
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    input  logic        flush,
    input  logic        core_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        pc_enable,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        instruction_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t state;
    logic   timeout;

    assign pc_enable = flush | (state == HOLD && core_ready);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          busy;
    logic          leaving;

    // A flush in WAIT moves to DROP, which restarts the count.
    assign busy    = (state == WAIT) || (state == DROP);
    assign leaving = mem_ack || (state == WAIT && flush);
    assign timeout = busy && !leaving && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (busy && !leaving && !timeout)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
            if (timeout)
                fetch_fault <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign fetch_fault        = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            mem_req           <= 1'b0;
            mem_addr          <= 32'h0;
            instruction       <= 32'h0;
            instruction_pc    <= 32'h0;
            instruction_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!flush && !fetch_fault) begin
                        mem_addr <= {pc_value[31:2], 2'b00};
                        mem_req  <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (mem_ack) begin
                        instruction       <= mem_rdata;
                        instruction_pc    <= mem_addr;
                        instruction_valid <= 1'b1;
                        mem_req           <= 1'b0;
                        state             <= HOLD;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    if (flush || core_ready) begin
                        instruction_valid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                DROP: begin
                    // The abandoned request stays up until memory answers it.
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a flag-based transaction model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_value = 32'h0;
    logic        flush = 1'b0;
    logic        core_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        pc_enable;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_valid;
    logic        fetch_fault;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .pc_value          (pc_value),
        .flush             (flush),
        .core_ready        (core_ready),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .pc_enable         (pc_enable),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_valid (instruction_valid),
        .fetch_fault       (fetch_fault)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: a request in flight, whether it is doomed, and the held word.
    logic        m_req;
    logic        m_drop;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          busy;
    int          lat;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req   = 1'b0;
        m_drop  = 1'b0;
        m_valid = 1'b0;
        m_addr  = 32'h0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        busy    = 1'b0;
        lat     = 0;
    endtask

    // Apply one cycle of inputs at the falling edge, compare, advance the model.
    task automatic drive(input logic f, input logic cr, input logic [31:0] pc,
                         input logic ack, input logic [31:0] rd);
        flush      = f;
        core_ready = cr;
        pc_value   = pc;
        mem_ack    = ack;
        mem_rdata  = rd;
        #1;
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("mem_addr", mem_addr, m_addr);
        chk("instruction", instruction, m_instr);
        chk("instruction_pc", instruction_pc, m_ipc);
        chk("instruction_valid", 32'(instruction_valid), 32'(m_valid));
        chk("fetch_fault", 32'(fetch_fault), 32'(0));
        chk("pc_enable", 32'(pc_enable), 32'(f | (m_valid & cr)));
        if (m_valid) begin
            if (f || cr)
                m_valid = 1'b0;
        end else if (m_req) begin
            if (ack) begin
                m_req = 1'b0;
                if (!f && !m_drop) begin
                    m_valid = 1'b1;
                    m_instr = rd;
                    m_ipc   = m_addr;
                end
                m_drop = 1'b0;
            end else if (f) begin
                m_drop = 1'b1;
            end
        end else if (!f) begin
            m_req  = 1'b1;
            m_addr = {pc[31:2], 2'b00};
        end
    endtask

    task automatic rnd_step();
        logic ack;
        ack = 1'b0;
        if (m_req) begin
            if (!busy) begin
                busy = 1'b1;
                lat  = int'($urandom_range(0, 3));
            end
            ack = (lat == 0);
            if (ack)
                busy = 1'b0;
            else
                lat--;
        end else begin
            busy = 1'b0;
        end
        drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              $urandom, ack, $urandom);
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instruction_pc", instruction_pc, 32'h0);
        chk("rst_valid", 32'(instruction_valid), 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        reset = 1'b1;

        // First fetch from 0, ack one cycle after the request.
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        chk("t1_no_req_in_idle", 32'(mem_req), 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        chk("t1_req_rise", 32'(mem_req), 32'h1);
        @(negedge clock);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h00500093);
        @(negedge clock);
        drive(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        chk("t1_instr", instruction, 32'h00500093);
        chk("t1_ipc", instruction_pc, 32'h0);
        chk("t1_valid", 32'(instruction_valid), 32'h1);
        chk("t1_pc_enable", 32'(pc_enable), 32'h1);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h4, 1'b0, 32'h0);
        chk("t1_pc_enable_fall", 32'(pc_enable), 32'h0);
        @(negedge clock);

        // Zero-latency fetch, then decode stalls for 5 cycles.
        drive(1'b0, 1'b0, 32'h4, 1'b1, 32'h11111111);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h4, 1'b0, 32'h0);
            chk("t2_instr", instruction, 32'h11111111);
            chk("t2_ipc", instruction_pc, 32'h4);
            chk("t2_valid", 32'(instruction_valid), 32'h1);
            chk("t2_pc_enable", 32'(pc_enable), 32'h0);
            chk("t2_mem_req", 32'(mem_req), 32'h0);
            @(negedge clock);
        end
        drive(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        @(negedge clock);

        // Flush while waiting; late ack carries a word that must vanish.
        drive(1'b0, 1'b0, 32'h8, 1'b0, 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h8, 1'b0, 32'h0);
        chk("t3_pc_enable", 32'(pc_enable), 32'h1);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h100, 1'b0, 32'h0);
            chk("t3_drop_req", 32'(mem_req), 32'h1);
            chk("t3_drop_addr", mem_addr, 32'h8);
            @(negedge clock);
        end
        drive(1'b0, 1'b0, 32'h100, 1'b1, 32'hDEADBEEF);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h100, 1'b0, 32'h0);
        chk("t3_instr_kept", instruction, 32'h11111111);
        chk("t3_valid", 32'(instruction_valid), 32'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h100, 1'b1, 32'hCAFEF00D);
        chk("t3_new_addr", mem_addr, 32'h100);
        chk("t4_pc_enable", 32'(pc_enable), 32'h1);
        @(negedge clock);

        // Flush with ack in the same cycle, then a misaligned target.
        drive(1'b0, 1'b0, 32'h106, 1'b0, 32'h0);
        chk("t4_valid", 32'(instruction_valid), 32'h0);
        chk("t4_req", 32'(mem_req), 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h106, 1'b0, 32'h0);
        chk("t5_align", mem_addr, 32'h104);
        chk("t5_req", 32'(mem_req), 32'h1);
        @(negedge clock);

        repeat (3000) rnd_step();

        // Reset dropped mid-stream clears everything immediately.
        while (!m_req) rnd_step();
        flush   = 1'b0;
        mem_ack = 1'b0;
        reset   = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'h0);
        chk("mid_rst_valid", 32'(instruction_valid), 32'h0);
        chk("mid_rst_instr", instruction, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (500) rnd_step();

`ifdef FETCH_TIMEOUT_EN
        begin
            int reqs;
            reqs    = 0;
            flush   = 1'b0;
            mem_ack = 1'b0;
            reset   = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            repeat (40) begin
                @(negedge clock);
                if (mem_req)
                    reqs++;
            end
            chk("to_wait_cycles", 32'(reqs), 32'd16);
            chk("to_fault", 32'(fetch_fault), 32'h1);
            chk("to_req_low", 32'(mem_req), 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
